// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 hex keypad matrix scanner with an 8-bit CPU slave.
// Registers: addr 0 = STATUS {valid, ovr, 2'b00, key}, addr 1 = DATA {4'h0, key}.
// Optional build macro: KPD_REPEAT_EN adds auto-repeat of a held key.
//
// state     | meaning
// ----------+-------------------------------------------------------
// S_IDLE    | no key held, waiting for a frame with exactly one key
// S_DEBOUNCE| candidate key seen, counting identical frames
// S_HELD    | key accepted, waiting for a frame with no key
// S_RELEASE | no key seen, counting empty frames before re-arming
module keypad_scan #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4,
  parameter int REPEAT   = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       read,
  input  logic       addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic [3:0] col_n,
  input  logic [3:0] row_n,
  output logic       irq
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE - 1);

  // Reject out-of-range parameters at elaboration time.
  if (SCAN_DIV < 4 || DEBOUNCE < 1 || REPEAT < 1) begin : g_param_check
    $error("keypad_scan: illegal parameter value");
  end

  typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_HELD, S_RELEASE} state_t;

  state_t           state;
  logic [3:0]       row_s1, row_s2;
  logic [DIV_W-1:0] div;
  logic [1:0]       col;
  logic [15:0]      snap;
  logic             frame_done;
  logic             tick;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       cand;
  logic [4:0]       ones;
  logic [3:0]       code;
  logic             hit;
  logic             accept;
  logic [3:0]       accept_code;
  logic             valid, ovr;
  logic [3:0]       key;
  logic             rd_data, ovr_clr;
  logic             unused_din;

`ifdef KPD_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT - 1);
  logic [REP_W-1:0] rcnt;
`endif

  assign tick       = (div == DIV_LAST);
  assign col_n      = ~(4'b0001 << col);
  assign irq        = valid;
  assign rd_data    = cs && read && addr;
  assign ovr_clr    = cs && !read && !addr && din[6];
  assign unused_din = ^{din[7], din[5:0]};

  // Two-flop synchronizer for the asynchronous row inputs (idle rows read high).
  always_ff @(posedge clk) begin
    if (!rst) begin
      row_s1 <= 4'hF;
      row_s2 <= 4'hF;
    end else begin
      row_s1 <= row_n;
      row_s2 <= row_s1;
    end
  end

  // Column slot timer, row snapshot per column, one-cycle frame_done after column 3.
  always_ff @(posedge clk) begin
    if (!rst) begin
      div        <= '0;
      col        <= 2'd0;
      snap       <= 16'h0000;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (tick) begin
        div                   <= '0;
        snap[{col, 2'b00} +: 4] <= ~row_s2;
        col                   <= col + 2'd1;
        frame_done            <= (col == 2'd3);
      end else begin
        div <= div + DIV_W'(1);
      end
    end
  end

  // Frame decode: a hit needs exactly one closed switch; the bit index is the key code.
  always_comb begin
    ones = 5'd0;
    code = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (snap[i]) begin
        ones = ones + 5'd1;
        code = 4'(i);
      end
    end
    hit = (ones == 5'd1);
  end

  // Accept event: debounce completes, or (with repeat) the repeat interval expires.
  always_comb begin
    accept      = 1'b0;
    accept_code = cand;
    if (frame_done && hit) begin
      case (state)
        S_IDLE: begin
          if (DEBOUNCE == 1) begin
            accept      = 1'b1;
            accept_code = code;
          end
        end
        S_DEBOUNCE: begin
          if (code == cand && cnt == DEB_LAST) accept = 1'b1;
        end
`ifdef KPD_REPEAT_EN
        S_HELD: begin
          if (code == cand && rcnt == REP_LAST) accept = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  // Press/release debounce FSM, advancing once per frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      cand  <= 4'd0;
`ifdef KPD_REPEAT_EN
      rcnt  <= '0;
`endif
    end else if (frame_done) begin
      case (state)
        S_IDLE: begin
          if (hit) begin
            cand  <= code;
            cnt   <= CNT_W'(1);
            state <= (DEBOUNCE == 1) ? S_HELD : S_DEBOUNCE;
`ifdef KPD_REPEAT_EN
            rcnt  <= '0;
`endif
          end
        end
        S_DEBOUNCE: begin
          if (hit && code == cand) begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == DEB_LAST) begin
              state <= S_HELD;
`ifdef KPD_REPEAT_EN
              rcnt  <= '0;
`endif
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_HELD: begin
          if (!hit) begin
            cnt   <= CNT_W'(1);
            state <= S_RELEASE;
          end
`ifdef KPD_REPEAT_EN
          else if (code == cand) begin
            rcnt <= (rcnt == REP_LAST) ? '0 : rcnt + REP_W'(1);
          end
`endif
        end
        S_RELEASE: begin
          if (!hit) begin
            cnt <= cnt + CNT_W'(1);
            if (cnt >= DEB_LAST) state <= S_IDLE;
          end else begin
            state <= S_HELD;
`ifdef KPD_REPEAT_EN
            rcnt  <= '0;
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // CPU register file: registered read data, pending flag, overrun flag, key code.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dout  <= 8'h00;
      valid <= 1'b0;
      ovr   <= 1'b0;
      key   <= 4'd0;
    end else begin
      if (cs && read) dout <= addr ? {4'h0, key} : {valid, ovr, 2'b00, key};
      if (accept) key <= accept_code;
      if (accept)       valid <= 1'b1;
      else if (rd_data) valid <= 1'b0;
      // A clear write beats a same-edge overrun; a same-edge DATA read consumes the old key.
      if (ovr_clr)                            ovr <= 1'b0;
      else if (accept && valid && !rd_data)   ovr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed tests for keypad_scan (SCAN_DIV=4, DEBOUNCE=2, REPEAT=3).
// Build with KPD_REPEAT_EN defined to exercise auto-repeat expectations.
module tb_keypad_scan;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cs = 1'b0;
  logic       read = 1'b0;
  logic       addr = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic       irq;

  logic       ka_on = 1'b0, kb_on = 1'b0;
  logic [1:0] ka_c = 2'd0, ka_r = 2'd0, kb_c = 2'd0, kb_r = 2'd0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  keypad_scan #(.SCAN_DIV(4), .DEBOUNCE(2), .REPEAT(3)) dut (
    .clk(clk), .rst(rst), .cs(cs), .read(read), .addr(addr), .din(din),
    .dout(dout), .col_n(col_n), .row_n(row_n), .irq(irq)
  );

  // Keypad model: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row_n = 4'hF;
    if (ka_on && !col_n[ka_c]) row_n[ka_r] = 1'b0;
    if (kb_on && !col_n[kb_c]) row_n[kb_r] = 1'b0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_read(input logic a, output logic [7:0] d);
    cs = 1'b1; read = 1'b1; addr = a;
    @(negedge clk);
    cs = 1'b0; read = 1'b0; addr = 1'b0;
    d = dout;
  endtask

  task automatic bus_write(input logic a, input logic [7:0] data);
    cs = 1'b1; read = 1'b0; addr = a; din = data;
    @(negedge clk);
    cs = 1'b0; din = 8'h00; addr = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Returns at the first negedge of a new frame (column 0 just selected).
  task automatic wait_frame_start();
    int n;
    n = 0;
    while (col_n !== 4'b0111 && n < 100) begin @(negedge clk); n++; end
    while (col_n !== 4'b1110 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL frame_align: got col_n=%b required frame start within 100 cycles", col_n);
    end
  endtask

  // Holds one key (optionally with a second key) for a whole number of aligned frames.
  task automatic press(input logic [1:0] c, input logic [1:0] r, input int frames, input logic with_b);
    wait_frame_start();
    ka_c = c; ka_r = r;
    ka_on = 1'b1; kb_on = with_b;
    cycles(16 * frames);
    ka_on = 1'b0; kb_on = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    rst = 1'b0;
    cycles(3);
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h required 00", dout); end
    checks++; if (col_n !== 4'b1110) begin errors++; $display("FAIL reset_col: got %b required 1110", col_n); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b required 0", irq); end
    rst = 1'b1;
    for (int k = 0; k < 16; k++) begin
      logic [3:0] exp_col;
      exp_col = ~(4'b0001 << ((k / 4) % 4));
      checks++;
      if (col_n !== exp_col) begin
        errors++; $display("FAIL col_walk[%0d]: got %b required %b", k, col_n, exp_col);
      end
      @(negedge clk);
    end
    cycles(24);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL idle_irq: got %b required 0", irq); end
    bus_read(1'b0, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL idle_status: got %h required 00", d); end
  endtask

  task automatic test_single_key();
    logic [7:0] d;
    press(2'd2, 2'd1, 4, 1'b0);
    cycles(48);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL key9_irq: got %b required 1", irq); end
    bus_read(1'b0, d);
    checks++; if (d !== 8'h89) begin errors++; $display("FAIL key9_status: got %h required 89", d); end
    bus_read(1'b1, d);
    checks++; if (d !== 8'h09) begin errors++; $display("FAIL key9_data: got %h required 09", d); end
    bus_read(1'b0, d);
    checks++; if (d !== 8'h09) begin errors++; $display("FAIL key9_status_after: got %h required 09", d); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL key9_irq_after: got %b required 0", irq); end
  endtask

  task automatic test_glitch();
    logic [7:0] d;
    apply_reset();
    press(2'd0, 2'd0, 1, 1'b0);
    cycles(48);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL glitch_irq: got %b required 0", irq); end
    bus_read(1'b0, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL glitch_status: got %h required 00", d); end
  endtask

  task automatic test_overrun();
    logic [7:0] d;
    press(2'd1, 2'd1, 3, 1'b0);
    cycles(48);
    press(2'd3, 2'd0, 3, 1'b0);
    cycles(48);
    bus_read(1'b0, d);
    checks++; if (d !== 8'hCC) begin errors++; $display("FAIL ovr_status: got %h required CC", d); end
    bus_write(1'b0, 8'h40);
    bus_read(1'b0, d);
    checks++; if (d !== 8'h8C) begin errors++; $display("FAIL ovr_cleared: got %h required 8C", d); end
    bus_read(1'b1, d);
    checks++; if (d !== 8'h0C) begin errors++; $display("FAIL ovr_data: got %h required 0C", d); end
  endtask

  task automatic test_chord_and_reset();
    logic [7:0] d;
    kb_c = 2'd1; kb_r = 2'd0;
    press(2'd0, 2'd0, 5, 1'b1);
    cycles(48);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL chord_irq: got %b required 0", irq); end
    bus_read(1'b0, d);
    checks++; if (d !== 8'h0C) begin errors++; $display("FAIL chord_status: got %h required 0C", d); end
    wait_frame_start();
    ka_c = 2'd1; ka_r = 2'd2; ka_on = 1'b1;
    cycles(20);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL midreset_dout: got %h required 00", dout); end
    checks++; if (col_n !== 4'b1110) begin errors++; $display("FAIL midreset_col: got %b required 1110", col_n); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL midreset_irq: got %b required 0", irq); end
    rst = 1'b1;
    cycles(48);
    ka_on = 1'b0;
    cycles(48);
    bus_read(1'b0, d);
    checks++; if (d !== 8'h86) begin errors++; $display("FAIL redebounce_status: got %h required 86", d); end
    bus_read(1'b1, d);
    checks++; if (d !== 8'h06) begin errors++; $display("FAIL redebounce_data: got %h required 06", d); end
  endtask

  task automatic test_repeat();
    int reads;
    int exp_reads;
`ifdef KPD_REPEAT_EN
    exp_reads = 3;
`else
    exp_reads = 1;
`endif
    reads = 0;
    wait_frame_start();
    ka_c = 2'd0; ka_r = 2'd3; ka_on = 1'b1;
    for (int n = 0; n < 160; n++) begin
      if (cs) begin
        cs = 1'b0; read = 1'b0; addr = 1'b0;
        reads++;
        checks++; if (dout !== 8'h03) begin errors++; $display("FAIL repeat_data: got %h required 03", dout); end
      end else if (irq) begin
        cs = 1'b1; read = 1'b1; addr = 1'b1;
      end
      @(negedge clk);
    end
    ka_on = 1'b0;
    if (cs) begin
      cs = 1'b0; read = 1'b0; addr = 1'b0;
      reads++;
      checks++; if (dout !== 8'h03) begin errors++; $display("FAIL repeat_data: got %h required 03", dout); end
    end
    cycles(48);
    checks++; if (reads != exp_reads) begin errors++; $display("FAIL repeat_count: got %0d required %0d", reads, exp_reads); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL repeat_irq_end: got %b required 0", irq); end
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_glitch();
    test_overrun();
    test_chord_and_reset();
    test_repeat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
